// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, decode and the
// regfile_wb_arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding pipeline (requesters, decode, regfile).
interface regfile_wb_arbiter_if;
  // ALU (single-cycle) writeback channel
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  // Long-latency writeback channel
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  // Long-latency issue from decode
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  // Decode hazard lookup
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic        hazard1;
  logic        hazard2;
  // Registered regfile write port
  logic        regfile_wren;
  logic [4:0]  write_addr3;
  logic [31:0] regfile_data_in3;

  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready,
    input  issue_valid, issue_addr,
    output issue_ready,
    input  read_addr1, read_addr2,
    output hazard1, hazard2,
    output regfile_wren, write_addr3, regfile_data_in3
  );

  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready,
    output issue_valid, issue_addr,
    input  issue_ready,
    output read_addr1, read_addr2,
    input  hazard1, hazard2,
    input  regfile_wren, write_addr3, regfile_data_in3
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter and pending-write scoreboard for the 32x32 regfile's
// single write port. Source A (ALU) and source B (long latency) compete for
// one registered write per cycle; a 32-bit busy vector tracks registers with
// an outstanding B result so decode can stall on RAW hazards.
//
// Build option: define WB_ARB_RR_EN for round-robin arbitration on conflict
// (the first conflict after reset goes to A). Without it, A always wins a
// conflict and no pointer flop exists.
module regfile_wb_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   wb_io
);

  // Grant / accept strobes for the current cycle
  logic        a_gnt_s;
  logic        b_gnt_s;
  logic        issue_acc_s;

  // Registered write stage
  logic        wren_q,  wren_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        src_b_q, src_b_d;

  // Scoreboard
  logic [31:0] busy_q, busy_d;
  logic [31:0] clr_mask_s;
  logic [31:0] set_mask_s;

`ifdef WB_ARB_RR_EN
  // 1 = B was granted most recently (also the reset value, so A wins first)
  logic        last_b_q, last_b_d;
`endif

  // Arbitrate between A and B; at most one grant per cycle
  always_comb begin
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    case ({wb_io.a_valid, wb_io.b_valid})
      2'b10: a_gnt_s = 1'b1;
      2'b01: b_gnt_s = 1'b1;
      2'b11: begin
`ifdef WB_ARB_RR_EN
        if (last_b_q) begin
          a_gnt_s = 1'b1;
        end else begin
          b_gnt_s = 1'b1;
        end
`else
        a_gnt_s = 1'b1;
`endif
      end
      default: begin
        a_gnt_s = 1'b0;
        b_gnt_s = 1'b0;
      end
    endcase
  end

`ifdef WB_ARB_RR_EN
  // Round-robin pointer next state: moves only when something is granted
  always_comb begin
    last_b_d = last_b_q;
    if (b_gnt_s) begin
      last_b_d = 1'b1;
    end else if (a_gnt_s) begin
      last_b_d = 1'b0;
    end else begin
      last_b_d = last_b_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`endif

  // Write-stage next state: capture the granted request; x0 is consumed silently
  always_comb begin
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    src_b_d = 1'b0;
    if (a_gnt_s) begin
      if (wb_io.a_addr != 5'd0) begin
        wren_d  = 1'b1;
        waddr_d = wb_io.a_addr;
        wdata_d = wb_io.a_data;
      end else begin
        wren_d  = 1'b0;
      end
      src_b_d = 1'b0;
    end else if (b_gnt_s) begin
      if (wb_io.b_addr != 5'd0) begin
        wren_d  = 1'b1;
        waddr_d = wb_io.b_addr;
        wdata_d = wb_io.b_data;
      end else begin
        wren_d  = 1'b0;
      end
      src_b_d = 1'b1;
    end else begin
      wren_d  = 1'b0;
      src_b_d = 1'b0;
    end
  end

  // Write-stage registers driving the regfile port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_q  <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      src_b_q <= 1'b0;
    end else begin
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      src_b_q <= src_b_d;
    end
  end

  // Scoreboard next state: clear on a committed B write, set on issue (set wins)
  always_comb begin
    issue_acc_s = wb_io.issue_valid & ~busy_q[wb_io.issue_addr];
    if (wren_q && src_b_q) begin
      clr_mask_s = 32'd1 << waddr_q;
    end else begin
      clr_mask_s = 32'd0;
    end
    if (issue_acc_s) begin
      set_mask_s = 32'd1 << wb_io.issue_addr;
    end else begin
      set_mask_s = 32'd0;
    end
    busy_d = ((busy_q & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Handshake and hazard outputs are combinational lookups; bit 0 is never busy
  assign wb_io.a_ready          = a_gnt_s;
  assign wb_io.b_ready          = b_gnt_s;
  assign wb_io.issue_ready      = ~busy_q[wb_io.issue_addr];
  assign wb_io.hazard1          = busy_q[wb_io.read_addr1];
  assign wb_io.hazard2          = busy_q[wb_io.read_addr2];
  assign wb_io.regfile_wren     = wren_q;
  assign wb_io.write_addr3      = waddr_q;
  assign wb_io.regfile_data_in3 = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps from the test
// plan followed by randomized traffic, all checked against a behavioural
// model (busy set, pending write, last-granted source).
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .wb_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model state
  bit [31:0] m_busy;
  bit        m_wren;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit        m_src_b;
  bit        m_ad_known;
  bit        m_last_b;
  // Grants the model computed for the most recent cycle
  bit        g_a, g_b, g_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.a_valid     = 1'b0;
    bus.b_valid     = 1'b0;
    bus.issue_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_busy     = 32'd0;
    m_wren     = 1'b0;
    m_addr     = 5'd0;
    m_data     = 32'd0;
    m_src_b    = 1'b0;
    m_ad_known = 1'b1;
    m_last_b   = 1'b1;
  endtask

  // Entered at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic cycle();
    bit exp_ir;
    #2;
    g_a = 1'b0;
    g_b = 1'b0;
    if (bus.a_valid && bus.b_valid) begin
`ifdef WB_ARB_RR_EN
      if (m_last_b) g_a = 1'b1;
      else          g_b = 1'b1;
`else
      g_a = 1'b1;
`endif
    end else begin
      g_a = bus.a_valid;
      g_b = bus.b_valid;
    end
    exp_ir = (bus.issue_addr == 5'd0) || !m_busy[bus.issue_addr];
    g_i    = bus.issue_valid && exp_ir;
    chk("a_ready", {31'd0, bus.a_ready}, {31'd0, g_a});
    chk("b_ready", {31'd0, bus.b_ready}, {31'd0, g_b});
    chk("issue_ready", {31'd0, bus.issue_ready}, {31'd0, exp_ir});
    chk("hazard1", {31'd0, bus.hazard1},
        {31'd0, (bus.read_addr1 != 5'd0) && m_busy[bus.read_addr1]});
    chk("hazard2", {31'd0, bus.hazard2},
        {31'd0, (bus.read_addr2 != 5'd0) && m_busy[bus.read_addr2]});
    // Scoreboard: committed B write retires, then a new issue claims (set wins)
    if (m_wren && m_src_b) m_busy[m_addr] = 1'b0;
    if (g_i && bus.issue_addr != 5'd0) m_busy[bus.issue_addr] = 1'b1;
    if (g_a || g_b) begin
      m_last_b   = g_b;
      m_src_b    = g_b;
      m_addr     = g_a ? bus.a_addr : bus.b_addr;
      m_data     = g_a ? bus.a_data : bus.b_data;
      m_wren     = (m_addr != 5'd0);
      m_ad_known = m_wren;
    end else begin
      m_wren  = 1'b0;
      m_src_b = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("regfile_wren", {31'd0, bus.regfile_wren}, {31'd0, m_wren});
    if (m_ad_known) begin
      chk("write_addr3", {27'd0, bus.write_addr3}, {27'd0, m_addr});
      chk("regfile_data_in3", bus.regfile_data_in3, m_data);
    end
  endtask

  // Entered at posedge+1; pulses reset through one edge.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    chk("rst_wren", {31'd0, bus.regfile_wren}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_addr", {27'd0, bus.write_addr3}, 32'd0);
    chk("rst_data", bus.regfile_data_in3, 32'd0);
    rst = 1'b0;
  endtask

  bit        pa, pb, pi;
  bit [4:0]  pa_addr, pb_addr, pi_addr;
  bit [31:0] pa_data, pb_data;
  logic [4:0] exp_w;

  initial begin
    rst = 1'b1;
    idle();
    bus.a_addr = 5'd0; bus.a_data = 32'd0;
    bus.b_addr = 5'd0; bus.b_data = 32'd0;
    bus.issue_addr = 5'd0;
    bus.read_addr1 = 5'd0; bus.read_addr2 = 5'd0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single ALU write to x5
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEAD_BEEF;
    cycle();
    chk("t1_wren", {31'd0, bus.regfile_wren}, 32'd1);
    chk("t1_addr", {27'd0, bus.write_addr3}, 32'd5);
    chk("t1_data", bus.regfile_data_in3, 32'hDEAD_BEEF);
    idle();
    cycle();
    chk("t1_wren_off", {31'd0, bus.regfile_wren}, 32'd0);
    chk("t1_hold_addr", {27'd0, bus.write_addr3}, 32'd5);

    // Conflict: A to x1 and B to x2 held together for 4 cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = $urandom;
      bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 32'h0000_B0B0;
      cycle();
`ifdef WB_ARB_RR_EN
      exp_w = (i % 2 == 0) ? 5'd1 : 5'd2;
`else
      exp_w = 5'd1;
`endif
      chk("conflict_grant", {27'd0, bus.write_addr3}, {27'd0, exp_w});
    end
    bus.a_valid = 1'b0;
    cycle();
    idle();
    cycle();

    // Issue to x7, second issue blocked, B write clears two cycles later
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd7; bus.read_addr1 = 5'd7;
    cycle();
    #1;
    chk("x7_hazard", {31'd0, bus.hazard1}, 32'd1);
    chk("x7_issue_blocked", {31'd0, bus.issue_ready}, 32'd0);
    cycle();
    bus.issue_valid = 1'b0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h7777_0007;
    cycle();
    idle();
    #1;
    chk("x7_hazard_n1", {31'd0, bus.hazard1}, 32'd1);
    cycle();
    #1;
    chk("x7_hazard_n2", {31'd0, bus.hazard1}, 32'd0);
    cycle();

    // B write to non-busy x3, then issue x3 as that write retires: set wins
    bus.read_addr1 = 5'd3;
    bus.b_valid = 1'b1; bus.b_addr = 5'd3; bus.b_data = 32'h3333_0003;
    cycle();
    idle();
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd3;
    #1;
    chk("x3_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    cycle();
    idle();
    #1;
    chk("x3_still_busy", {31'd0, bus.hazard1}, 32'd1);
    cycle();

    // x0 write and x0 issue
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'h0000_1234;
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd0;
    bus.read_addr1 = 5'd0; bus.read_addr2 = 5'd0;
    #1;
    chk("x0_a_ready", {31'd0, bus.a_ready}, 32'd1);
    chk("x0_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    cycle();
    chk("x0_wren", {31'd0, bus.regfile_wren}, 32'd0);
    idle();
    #1;
    chk("x0_hazard", {31'd0, bus.hazard1}, 32'd0);
    cycle();

    // Randomized traffic with hold-until-ready requesters
    pa = 1'b0; pb = 1'b0; pi = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!pa && $urandom_range(0, 99) < 50) begin
        pa = 1'b1;
        pa_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        pa_data = $urandom;
      end
      if (!pb && $urandom_range(0, 99) < 40) begin
        pb = 1'b1;
        pb_addr = 5'($urandom_range(0, 7));
        pb_data = $urandom;
      end
      if (!pi && $urandom_range(0, 99) < 30) begin
        pi = 1'b1;
        pi_addr = 5'($urandom_range(0, 7));
      end
      bus.a_valid = pa; bus.a_addr = pa_addr; bus.a_data = pa_data;
      bus.b_valid = pb; bus.b_addr = pb_addr; bus.b_data = pb_data;
      bus.issue_valid = pi; bus.issue_addr = pi_addr;
      bus.read_addr1 = 5'($urandom_range(0, 7));
      bus.read_addr2 = 5'($urandom_range(0, 7));
      cycle();
      if (g_a) pa = 1'b0;
      if (g_b) pb = 1'b0;
      if (g_i) pi = 1'b0;
    end

    // Asynchronous reset while a write is pending and x9 is busy
    idle();
    cycle();
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
    bus.b_valid = 1'b0;
    bus.read_addr1 = 5'd9;
    if (m_busy[9]) bus.issue_valid = 1'b0;
    cycle();
    idle();
    bus.a_valid = 1'b1; bus.a_addr = 5'd4; bus.a_data = 32'h4444_4444;
    cycle();
    idle();
    #1;
    chk("pre_rst_wren", {31'd0, bus.regfile_wren}, 32'd1);
    chk("pre_rst_hazard9", {31'd0, bus.hazard1}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_wren", {31'd0, bus.regfile_wren}, 32'd0);
    chk("async_rst_hazard9", {31'd0, bus.hazard1}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and pending-write scoreboard in front of the 32x32 register file's single write port. Two writeback sources compete for the port: A is the single-cycle ALU path and B is the multi-cycle load/long-latency path. The block grants one of them per cycle and drives a registered write to the regfile. It also tracks which registers have an outstanding B result, so decode can stall on RAW hazards.

## Interface
Parameters:
- none; widths are fixed by the regfile (32 registers, 5-bit address, 32-bit data)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- a_valid  input  1  ALU writeback request
- a_addr  input  5  ALU destination register
- a_data  input  32  ALU result
- a_ready  output  1  ALU request accepted this cycle (combinational)
- b_valid  input  1  long-latency writeback request
- b_addr  input  5  long-latency destination register
- b_data  input  32  long-latency result
- b_ready  output  1  long-latency request accepted this cycle (combinational)
- issue_valid  input  1  decode issues a long-latency op
- issue_addr  input  5  its destination register
- issue_ready  output  1  issue accepted (combinational)
- read_addr1  input  5  decode source 1
- read_addr2  input  5  decode source 2
- hazard1  output  1  source 1 has an outstanding B write
- hazard2  output  1  source 2 has an outstanding B write
- regfile_wren  output  1  registered write enable to the regfile
- write_addr3  output  5  registered write address
- regfile_data_in3  output  32  registered write data

## Operation
- Handshakes are valid/ready. A requester holds valid, addr and data stable until it sees ready.
- A request is accepted in the cycle where valid&ready is high.
- At most one of a_ready/b_ready is high in any cycle.
- If only one requester is valid, it is granted.
- If both are valid, arbitration follows Configuration.
- The output stage never back-pressures: a granted request always writes on the next edge.
- Accepted request to x0: consumed (ready high), but regfile_wren stays 0 for it.
- Scoreboard: 32 busy bits, with bit 0 always 0.
  - issue_ready = ~busy[issue_addr]. issue_addr==0 is always ready and sets nothing.
  - An accepted issue sets busy[issue_addr].
  - busy[write_addr3] clears at the end of a cycle in which regfile_wren=1 and the registered write came from B.
  - A writes never clear busy bits.
  - Set and clear of the same bit in the same cycle: set wins.
- hazard1 = busy[read_addr1]; hazard2 = busy[read_addr2]. Both are combinational; x0 never flags a hazard.
- B requests to non-busy registers are legal: written normally, scoreboard unchanged.

## Timing
- Grant is combinational in cycle N. regfile_wren, write_addr3 and regfile_data_in3 are valid in cycle N+1.
- The regfile captures the write at the end of cycle N+1.
- busy clears on the same edge the regfile captures the write. From cycle N+2, hazard is low and a regfile read returns the new value.
- Cycle with no grant: regfile_wren=0 next cycle; write_addr3 and regfile_data_in3 hold their previous values.
- Reset, asynchronous and immediate:
  - regfile_wren=0, write_addr3=0, regfile_data_in3=0
  - all busy bits 0
  - round-robin pointer = "B last granted"
- Reset mid-operation drops any registered write (wren forced 0) and any outstanding scoreboard entries.
- Throughput: one write per cycle, sustained.

## Configuration
- WB_ARB_RR_EN defined: round-robin.
  - On conflict, grant the requester not granted most recently.
  - The pointer updates only on a grant.
  - The first conflict after reset goes to A.
- WB_ARB_RR_EN undefined: fixed priority, A always wins on conflict. B may starve. The pointer flop is not built.

## Test plan
- Reset, then a_valid with a_addr=5 and a_data=0xDEADBEEF in cycle 1 -> a_ready=1 in cycle 1; regfile_wren=1, write_addr3=5, regfile_data_in3=0xDEADBEEF in cycle 2; wren=0 in cycle 3.
- a_valid and b_valid held together for 4 cycles (addrs 1 and 2):
  - with WB_ARB_RR_EN -> grants A,B,A,B
  - without it -> grants A,A,A,A, with b_ready=0 throughout
- Issue to x7 -> hazard1=1 for read_addr1=7 and issue_ready=0 for a second issue to x7. A B write to x7 granted in cycle N -> hazard1 still 1 in N+1, 0 in N+2.
- Issue to x3 in the same cycle the registered B write to x3 clears -> busy[3] stays 1.
- a_valid to x0 with data 0x1234 -> a_ready=1, regfile_wren stays 0. issue_addr=0 -> issue_ready=1 and hazard for read_addr=0 stays 0.
- Asserting rst while regfile_wren=1 and busy[9]=1 -> regfile_wren=0 and hazard for x9=0 immediately, before the next clock edge.
